// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Arbitrates register-file writeback between the ALU and the load unit,
//   drives a registered register-file write port, and keeps a busy
//   scoreboard of destination registers reserved at issue.
//
// Parameters
//   RR_MODE       1 = round-robin between ALU and LD, 0 = fixed ALU priority
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   alu_valid     ALU writeback request        alu_ready  ALU grant
//   alu_rd        ALU destination register     alu_data   ALU write data
//   ld_valid      load writeback request       ld_ready   load grant
//   ld_rd         load destination register    ld_data    load write data
//   load_enable   registered register-file write enable
//   rc / ry       registered write address / write data
//   iss_valid     issue-stage reservation      iss_rd     reserved register
//   qa / qb       source registers to check    hazard_a/b hazard flags
//   busy          scoreboard vector (bit 0 always 0)
//   conflict_cnt  saturating count of cycles with both requesters valid
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int RR_MODE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        load_enable,
    output logic [4:0]  rc,
    output logic [31:0] ry,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  qa,
    input  logic [4:0]  qb,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic [31:0] busy,
    output logic [15:0] conflict_cnt
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_e;

    grant_e      last_grant_q, last_grant_d;
    logic        load_enable_q, load_enable_d;
    logic [4:0]  rc_q, rc_d;
    logic [31:0] ry_q, ry_d;
    logic [31:0] busy_q, busy_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    logic        alu_wins;
    logic        alu_xfer;
    logic        ld_xfer;
    logic        xfer;
    logic [4:0]  xfer_rd;
    logic [31:0] xfer_data;

    // ALU wins a conflict under fixed priority, or in round-robin when the
    // load unit had the previous grant.
    always_comb begin
        alu_wins = 1'b1;
        if (RR_MODE != 0) begin
            alu_wins = (last_grant_q == GRANT_LD);
        end
    end

    // Readies are gated by rst_n so nothing is granted while in reset.
    assign alu_ready = rst_n & alu_valid & (~ld_valid | alu_wins);
    assign ld_ready  = rst_n & ld_valid  & (~alu_valid | ~alu_wins);

    assign alu_xfer  = alu_valid & alu_ready;
    assign ld_xfer   = ld_valid & ld_ready;
    assign xfer      = alu_xfer | ld_xfer;
    assign xfer_rd   = alu_xfer ? alu_rd   : ld_rd;
    assign xfer_data = alu_xfer ? alu_data : ld_data;

    always_comb begin
        last_grant_d   = last_grant_q;
        load_enable_d  = 1'b0;
        rc_d           = rc_q;
        ry_d           = ry_q;
        busy_d         = busy_q;
        conflict_cnt_d = conflict_cnt_q;

        if (alu_xfer) begin
            last_grant_d = GRANT_ALU;
        end else if (ld_xfer) begin
            last_grant_d = GRANT_LD;
        end

        // Writes to r0 complete the handshake but never reach the file.
        if (xfer && (xfer_rd != 5'd0)) begin
            load_enable_d   = 1'b1;
            rc_d            = xfer_rd;
            ry_d            = xfer_data;
            busy_d[xfer_rd] = 1'b0;
        end

        // Applied after the clear so a same-register reservation wins.
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (alu_valid && ld_valid && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q   <= GRANT_LD;
            load_enable_q  <= 1'b0;
            rc_q           <= '0;
            ry_q           <= '0;
            busy_q         <= '0;
            conflict_cnt_q <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            load_enable_q  <= load_enable_d;
            rc_q           <= rc_d;
            ry_q           <= ry_d;
            busy_q         <= busy_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign load_enable  = load_enable_q;
    assign rc           = rc_q;
    assign ry           = ry_q;
    assign busy         = busy_q;
    assign conflict_cnt = conflict_cnt_q;

    // The write-port term covers the cycle after the scoreboard has been
    // cleared but before the register file holds the new value.
    assign hazard_a = (qa != 5'd0) & (busy_q[qa] | (load_enable_q & (rc_q == qa)));
    assign hazard_b = (qb != 5'd0) & (busy_q[qb] | (load_enable_q & (rc_q == qb)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  qa;
    logic [4:0]  qb;

    logic        r1_alu_ready, r1_ld_ready, r1_le, r1_haz_a, r1_haz_b;
    logic [4:0]  r1_rc;
    logic [31:0] r1_ry, r1_busy;
    logic [15:0] r1_cnt;

    logic        r0_alu_ready, r0_ld_ready, r0_le, r0_haz_a, r0_haz_b;
    logic [4:0]  r0_rc;
    logic [31:0] r0_ry, r0_busy;
    logic [15:0] r0_cnt;

    int checks;
    int errors;

    regfile_wb_arbiter #(.RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(r1_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(r1_ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .load_enable(r1_le), .rc(r1_rc), .ry(r1_ry),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .qa(qa), .qb(qb),
        .hazard_a(r1_haz_a), .hazard_b(r1_haz_b), .busy(r1_busy), .conflict_cnt(r1_cnt)
    );

    regfile_wb_arbiter #(.RR_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(r0_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(r0_ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .load_enable(r0_le), .rc(r0_rc), .ry(r0_ry),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .qa(qa), .qb(qb),
        .hazard_a(r0_haz_a), .hazard_b(r0_haz_b), .busy(r0_busy), .conflict_cnt(r0_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h0;
        ld_valid  = 1'b1;
        ld_rd     = 5'd2;
        ld_data   = 32'h0;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        qa        = 5'd0;
        qb        = 5'd0;

        // Reset: no grants even with both requesters valid
        #3;
        chk1("rst_alu_ready_rr", r1_alu_ready, 1'b0);
        chk1("rst_ld_ready_rr", r1_ld_ready, 1'b0);
        chk1("rst_alu_ready_fp", r0_alu_ready, 1'b0);
        tick();
        tick();
        chk1("rst_le", r1_le, 1'b0);
        chk32("rst_busy", r1_busy, 32'h0);
        chk32("rst_cnt", 32'(r1_cnt), 32'h0);
        chk32("rst_rc", 32'(r1_rc), 32'h0);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        rst_n     = 1'b1;
        tick();

        // ALU-only write to r3
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h0000_0011;
        #1;
        chk1("alu_only_ready", r1_alu_ready, 1'b1);
        chk1("alu_only_ld_ready", r1_ld_ready, 1'b0);
        tick();
        alu_valid = 1'b0;
        chk1("alu_only_le", r1_le, 1'b1);
        chk32("alu_only_rc", 32'(r1_rc), 32'd3);
        chk32("alu_only_ry", r1_ry, 32'h11);
        tick();
        chk1("alu_only_le_drop", r1_le, 1'b0);
        chk32("alu_only_rc_hold", 32'(r1_rc), 32'd3);
        chk32("alu_only_ry_hold", r1_ry, 32'h11);

        // LD-only write to r0: completes, no write, moves last grant to LD
        ld_valid = 1'b1;
        ld_rd    = 5'd0;
        ld_data  = 32'hDEAD_BEEF;
        #1;
        chk1("ld_r0_ready", r1_ld_ready, 1'b1);
        tick();
        ld_valid = 1'b0;
        chk1("ld_r0_le", r1_le, 1'b0);
        chk32("ld_r0_ry_hold", r1_ry, 32'h11);
        chk32("ld_r0_busy", r1_busy, 32'h0);

        // Four conflict cycles, back to back
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'hA1;
        ld_valid  = 1'b1;
        ld_rd     = 5'd2;
        ld_data   = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("rr_alu_ready", r1_alu_ready, (i % 2) == 0);
            chk1("rr_ld_ready", r1_ld_ready, (i % 2) == 1);
            chk1("fp_alu_ready", r0_alu_ready, 1'b1);
            chk1("fp_ld_ready", r0_ld_ready, 1'b0);
            tick();
            chk1("rr_le", r1_le, 1'b1);
            chk32("rr_rc", 32'(r1_rc), ((i % 2) == 0) ? 32'd1 : 32'd2);
            chk32("rr_ry", r1_ry, ((i % 2) == 0) ? 32'hA1 : 32'hB2);
            chk32("fp_rc", 32'(r0_rc), 32'd1);
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        chk32("rr_cnt4", 32'(r1_cnt), 32'd4);
        chk32("fp_cnt4", 32'(r0_cnt), 32'd4);
        tick();
        chk1("rr_le_idle", r1_le, 1'b0);

        // Hazard on r5 until the load writes it
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        qa        = 5'd5;
        qb        = 5'd0;
        tick();
        iss_valid = 1'b0;
        #1;
        chk32("haz_busy", r1_busy, 32'h0000_0020);
        chk1("haz_a_set", r1_haz_a, 1'b1);
        chk1("haz_b_r0", r1_haz_b, 1'b0);
        tick();
        chk1("haz_a_hold", r1_haz_a, 1'b1);
        ld_valid = 1'b1;
        ld_rd    = 5'd5;
        ld_data  = 32'h55;
        #1;
        chk1("haz_ld_ready", r1_ld_ready, 1'b1);
        tick();
        ld_valid = 1'b0;
        chk32("haz_busy_clr", r1_busy, 32'h0);
        chk1("haz_le", r1_le, 1'b1);
        chk32("haz_rc", 32'(r1_rc), 32'd5);
        chk1("haz_a_write_cycle", r1_haz_a, 1'b1);
        qb = 5'd5;
        #1;
        chk1("haz_b_write_cycle", r1_haz_b, 1'b1);
        tick();
        chk1("haz_a_clear", r1_haz_a, 1'b0);
        qb = 5'd0;

        // Same-register reserve and write: reservation wins
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h77;
        tick();
        chk32("same_reg_busy", r1_busy, 32'h0000_0080);
        chk1("same_reg_le", r1_le, 1'b1);
        // Different registers: both take effect
        iss_rd = 5'd2;
        tick();
        chk32("diff_reg_busy", r1_busy, 32'h0000_0004);
        // Write to r0 leaves busy untouched
        iss_valid = 1'b0;
        alu_rd    = 5'd0;
        tick();
        chk1("r0_write_le", r1_le, 1'b0);
        chk32("r0_write_busy", r1_busy, 32'h0000_0004);

        // Latch a write with busy = 0x24, then reset mid-cycle
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        alu_rd    = 5'd9;
        alu_data  = 32'h99;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        chk1("pre_rst_le", r1_le, 1'b1);
        chk32("pre_rst_busy", r1_busy, 32'h0000_0024);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_le", r1_le, 1'b0);
        chk32("async_rst_busy", r1_busy, 32'h0);
        chk32("async_rst_cnt", 32'(r1_cnt), 32'h0);
        chk32("async_rst_ry", r1_ry, 32'h0);
        #1;
        rst_n = 1'b1;

        // Saturation of the conflict counter
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'hC1;
        ld_valid  = 1'b1;
        ld_rd     = 5'd2;
        ld_data   = 32'hC2;
        #1;
        chk1("post_rst_alu_first", r1_alu_ready, 1'b1);
        tick();
        chk1("post_rst_le", r1_le, 1'b1);
        chk32("post_rst_rc", 32'(r1_rc), 32'd1);
        chk32("post_rst_cnt", 32'(r1_cnt), 32'd1);
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        chk32("sat_cnt_reach", 32'(r1_cnt), 32'h0000_FFFF);
        tick();
        chk32("sat_cnt_hold_rr", 32'(r1_cnt), 32'h0000_FFFF);
        chk32("sat_cnt_hold_fp", 32'(r0_cnt), 32'h0000_FFFF);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
